// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication sequencer: packed point
// format, point-ALU opcodes and the sequencer state type.
package ecc_pkg;

    localparam int unsigned FE_W    = 4;
    localparam int unsigned POINT_W = 3 * FE_W;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_DBL = 1'b1;

    typedef logic [FE_W-1:0]    fe_t;
    typedef logic [POINT_W-1:0] point_t;

    // Projective point at infinity: X=0, Y=1, Z=0.
    localparam point_t POINT_INF = 12'h010;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StDbl,
        StAdd,
        StDone
    } state_e;

    function automatic fe_t point_x(input point_t p);
        return p[FE_W-1:0];
    endfunction

    function automatic fe_t point_y(input point_t p);
        return p[2*FE_W-1:FE_W];
    endfunction

    function automatic fe_t point_z(input point_t p);
        return p[3*FE_W-1:2*FE_W];
    endfunction

    function automatic point_t point_pack(input fe_t x, input fe_t y, input fe_t z);
        return {z, y, x};
    endfunction

endpackage

// File: rtl/ecc_scalar_mult_if.sv
// Upstream start/busy/done handshake plus the downstream point-ALU bus.
interface ecc_scalar_mult_if #(
    parameter int unsigned K_WIDTH = 8
);
    logic                       start;
    logic [K_WIDTH-1:0]         k;
    logic [ecc_pkg::POINT_W-1:0] p_in;
    logic                       busy;
    logic                       done;
    logic [ecc_pkg::POINT_W-1:0] result;
    logic                       alu_op;
    logic [ecc_pkg::POINT_W-1:0] alu_a;
    logic [ecc_pkg::POINT_W-1:0] alu_b;
    logic [ecc_pkg::POINT_W-1:0] alu_r;

    // master: the sequencer; slave: front end and point ALU around it.
    modport master (
        input  start, k, p_in, alu_r,
        output busy, done, result, alu_op, alu_a, alu_b
    );

    modport slave (
        output start, k, p_in, alu_r,
        input  busy, done, result, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/ecc_scalar_mult.sv
// Left-to-right double-and-add sequencer computing Q = k*P by driving an
// external combinational point ALU.
module ecc_scalar_mult
    import ecc_pkg::*;
#(
    parameter int unsigned K_WIDTH = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    ecc_scalar_mult_if.master bus
);

    localparam int unsigned IW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    state_e             state_q, state_d;
    logic [K_WIDTH-1:0] kr_q, kr_d;
    point_t             pr_q, pr_d;
    point_t             q_q, q_d;
    logic [IW-1:0]      i_q, i_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               op_q, op_d;
    point_t             a_q, a_d;
    point_t             b_q, b_d;
    point_t             result_q, result_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            kr_q     <= '0;
            pr_q     <= '0;
            q_q      <= '0;
            i_q      <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            kr_q     <= kr_d;
            pr_q     <= pr_d;
            q_q      <= q_d;
            i_q      <= i_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kr_d     = kr_q;
        pr_d     = pr_q;
        q_d      = q_q;
        i_d      = i_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    kr_d    = bus.k;
                    pr_d    = bus.p_in;
                    i_d     = IW'(K_WIDTH - 1);
                    state_d = StScan;
                end
            end
            StScan: begin
                if (kr_q[i_q]) begin
                    q_d = pr_q;
                    if (i_q == '0) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q - 1'b1;
                        op_d    = ALU_OP_DBL;
                        a_d     = pr_q;
                        b_d     = pr_q;
                        cnt_d   = '0;
                        state_d = StDbl;
                    end
                end else if (i_q == '0) begin
                    q_d     = POINT_INF;
                    state_d = StDone;
                end else begin
                    i_d = i_q - 1'b1;
                end
            end
            StDbl: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    q_d   = bus.alu_r;
                    cnt_d = '0;
                    if (kr_q[i_q]) begin
                        op_d    = ALU_OP_ADD;
                        a_d     = bus.alu_r;
                        b_d     = pr_q;
                        state_d = StAdd;
                    end else if (i_q == '0) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q - 1'b1;
                        a_d     = bus.alu_r;
                        state_d = StDbl;
                    end
                end
            end
            StAdd: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    q_d   = bus.alu_r;
                    cnt_d = '0;
                    if (i_q == '0) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q - 1'b1;
                        op_d    = ALU_OP_DBL;
                        a_d     = bus.alu_r;
                        b_d     = pr_q;
                        state_d = StDbl;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Publish Q on the edge entering DONE so it is valid with the pulse.
        if (state_d == StDone && state_q != StDone) begin
            result_d = q_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.alu_op = op_q;
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;

endmodule

// File: tb/tb_ecc_scalar_mult.sv
// Bench for ecc_scalar_mult: two instances (ALU_LAT 1 and 3) with a modular
// add/double stub ALU, directed vector table plus reset and restart sequences.
module tb_ecc_scalar_mult;
    import ecc_pkg::*;

    localparam int unsigned LAT0  = 1;
    localparam int unsigned LAT1  = 3;
    localparam int          BOUND = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  k = '0;
    logic [11:0] p_in = '0;

    always #5 clk = ~clk;

    ecc_scalar_mult_if #(.K_WIDTH(8)) bus0 ();
    ecc_scalar_mult_if #(.K_WIDTH(8)) bus1 ();

    assign bus0.start = start;
    assign bus0.k     = k;
    assign bus0.p_in  = p_in;
    assign bus0.alu_r = bus0.alu_op ? {bus0.alu_a[10:0], 1'b0} : bus0.alu_a + bus0.alu_b;
    assign bus1.start = start;
    assign bus1.k     = k;
    assign bus1.p_in  = p_in;
    assign bus1.alu_r = bus1.alu_op ? {bus1.alu_a[10:0], 1'b0} : bus1.alu_a + bus1.alu_b;

    ecc_scalar_mult #(.K_WIDTH(8), .ALU_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    ecc_scalar_mult #(.K_WIDTH(8), .ALU_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    typedef struct {
        logic        done;
        logic        op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] result;
    } samp_t;

    typedef struct {
        logic [7:0]  k;
        logic [11:0] p;
        logic [11:0] exp;
    } vec_t;

    samp_t tr0[$];
    samp_t tr1[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Start one run on both instances and record every busy cycle of each.
    task automatic run(input logic [7:0] kk, input logic [11:0] pp);
        int cyc;
        tr0.delete();
        tr1.delete();
        @(negedge clk);
        k     = kk;
        p_in  = pp;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            if (bus0.busy) tr0.push_back('{bus0.done, bus0.alu_op, bus0.alu_a, bus0.alu_b,
                                           bus0.result});
            if (bus1.busy) tr1.push_back('{bus1.done, bus1.alu_op, bus1.alu_a, bus1.alu_b,
                                           bus1.result});
            cyc++;
        end while ((bus0.busy || bus1.busy) && cyc < BOUND);
        if (cyc >= BOUND) check("run_timeout", 32'(cyc), 32'(BOUND - 1));
    endtask

    // Compare a recorded run against cycle counts and an op trace derived
    // from the double-and-add recurrence.
    task automatic check_run(input string tag, input int lat, input logic [7:0] kk,
                             input logic [11:0] pp, input logic [11:0] exp, input samp_t tr[$]);
        int          msb;
        int          scan;
        int          nops;
        int          blen;
        int          ndone;
        int          bad;
        logic        eop[$];
        logic [11:0] ea[$];
        logic [11:0] q;
        msb = -1;
        for (int b = 7; b >= 0; b--) if (kk[b] && msb < 0) msb = b;
        scan = (msb < 0) ? 8 : 8 - msb;
        nops = (msb < 0) ? 0 : msb + $countones(kk) - 1;
        blen = scan + lat * nops + 1;
        check({tag, "_busy_len"}, 32'(tr.size()), 32'(blen));
        ndone = 0;
        foreach (tr[j]) if (tr[j].done) ndone++;
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        if (tr.size() > 0) begin
            check({tag, "_done_last"}, {31'd0, tr[tr.size()-1].done}, 32'd1);
            check({tag, "_result"}, {20'd0, tr[tr.size()-1].result}, {20'd0, exp});
        end else begin
            check({tag, "_empty"}, 32'(tr.size()), 32'(blen));
        end
        q = pp;
        for (int b = msb - 1; b >= 0; b--) begin
            eop.push_back(ALU_OP_DBL);
            ea.push_back(q);
            q = {q[10:0], 1'b0};
            if (kk[b]) begin
                eop.push_back(ALU_OP_ADD);
                ea.push_back(q);
                q = q + pp;
            end
        end
        bad = 0;
        if (tr.size() < scan + lat * eop.size()) begin
            bad = 1;
        end else begin
            for (int g = 0; g < eop.size(); g++) begin
                for (int j = 0; j < lat; j++) begin
                    if (tr[scan + g*lat + j].op !== eop[g] || tr[scan + g*lat + j].a !== ea[g] ||
                        tr[scan + g*lat + j].b !== pp) bad++;
                end
            end
        end
        check({tag, "_op_trace_errors"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs[8];
    int   cyc;
    logic seen;

    initial begin
        vecs[0] = '{8'h05, 12'h123, 12'h5AF};
        vecs[1] = '{8'h00, 12'h123, 12'h010};
        vecs[2] = '{8'h01, 12'h123, 12'h123};
        vecs[3] = '{8'hFF, 12'h001, 12'h0FF};
        vecs[4] = '{8'h02, 12'h123, 12'h246};
        vecs[5] = '{8'h03, 12'h123, 12'h369};
        vecs[6] = '{8'h80, 12'h001, 12'h080};
        vecs[7] = '{8'hA5, 12'h00F, 12'h9AB};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {30'd0, bus1.busy, bus0.busy}, 32'd0);
        check("rst_done", {30'd0, bus1.done, bus0.done}, 32'd0);
        check("rst_result", {8'd0, bus0.result, bus1.result}, 32'd0);
        check("rst_alu", {7'd0, bus0.alu_op, bus0.alu_a, bus0.alu_b}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run(vecs[v].k, vecs[v].p);
            check_run($sformatf("v%0d_lat1", v), LAT0, vecs[v].k, vecs[v].p, vecs[v].exp, tr0);
            check_run($sformatf("v%0d_lat3", v), LAT1, vecs[v].k, vecs[v].p, vecs[v].exp, tr1);
        end

        // Asynchronous reset in the middle of a doubling chain.
        @(negedge clk);
        k = 8'h80;
        p_in = 12'h123;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", {31'd0, bus0.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {30'd0, bus1.busy, bus0.busy}, 32'd0);
        check("mid_rst_done", {30'd0, bus1.done, bus0.done}, 32'd0);
        check("mid_rst_result", {8'd0, bus0.result, bus1.result}, 32'd0);
        check("mid_rst_alu", {7'd0, bus0.alu_op, bus0.alu_a, bus0.alu_b}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.done || bus1.done || bus0.busy || bus1.busy) seen = 1'b1;
        end
        check("no_activity_after_rst", {31'd0, seen}, 32'd0);
        run(8'h03, 12'h010);
        check_run("after_rst_lat1", LAT0, 8'h03, 12'h010, 12'h030, tr0);
        check_run("after_rst_lat3", LAT1, 8'h03, 12'h010, 12'h030, tr1);

        // start held high, operand inputs changed mid-run, then back-to-back.
        @(negedge clk);
        k = 8'h05;
        p_in = 12'h123;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) @(negedge clk);
        k = 8'hFF;
        p_in = 12'h001;
        cyc = 0;
        while (!bus0.done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_first_done_seen", {31'd0, bus0.done}, 32'd1);
        check("hold_first_result", {20'd0, bus0.result}, 32'h5AF);
        k = 8'h03;
        p_in = 12'h010;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus0.done && cyc < BOUND);
        check("b2b_done_cycles", 32'(cyc), 32'd11);
        check("b2b_result", {20'd0, bus0.result}, 32'h030);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_scalar_mult.md
Name: ecc_scalar_mult

Overview:
- Sequencer for elliptic-curve scalar multiplication Q = k·P, using left-to-right double-and-add.
- It is the initiator that drives the team's point-ALU interface (op/A/B in, R out) and consumes its results; the ALU is instantiated outside this block.
- Points use the shared packed projective format: X=[3:0], Y=[7:4], Z=[11:8].
- Sits between the key/scalar front end and the point ALU; exposes a start/busy/done handshake upstream.

Parameters:
- K_WIDTH, 8: scalar width in bits.
- ALU_LAT, 1: cycles operands are held stable before alu_r is captured (≥1).
- POINT_W, 12: packed point width; fixed by package, not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- k  in  K_WIDTH  scalar; latched when start is accepted.
- p_in  in  12  base point P; latched when start is accepted.
- busy  out  1  high from the accept edge until DONE exits.
- done  out  1  one-cycle pulse; result is valid from this cycle.
- result  out  12  Q; held until the next accepted start.
- alu_op  out  1  0=add, 1=double (package constants).
- alu_a  out  12  ALU operand A (accumulator Q).
- alu_b  out  12  ALU operand B (P for add; don't-care, driven P, for double).
- alu_r  in  12  ALU result, combinational from alu_op/alu_a/alu_b.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State→IDLE; busy=0, done=0, result=0, alu_op=0, alu_a=0, alu_b=0, wait counter=0.
  - Any in-flight operation is abandoned; no done pulse.
- States: IDLE, SCAN, DBL, ADD, DONE. Index register i, width clog2(K_WIDTH).
- IDLE:
  - If start=1: latch k→kr and p_in→pr; i=K_WIDTH-1; busy=1; go SCAN.
  - start while busy is ignored, not queued.
- SCAN (one bit per cycle, MSB first):
  - kr[i]=1: Q=pr. If i==0 go DONE; else i--, load operands for DBL, go DBL.
  - kr[i]=0 and i==0: Q=POINT_INF (12'h010), go DONE.
  - Otherwise: i--, stay in SCAN.
- Operands alu_op/alu_a/alu_b are registered and updated on the edge entering DBL/ADD, using the Q value committed at that same edge. They stay stable for ALU_LAT cycles. On the last of those cycles' edge, Q=alu_r.
- DBL completion:
  - kr[i]=1: go ADD (alu_op=0, alu_a=alu_r, alu_b=pr).
  - Else if i==0: go DONE.
  - Else: i--, go DBL again (alu_a=alu_r).
- ADD completion:
  - i==0: go DONE.
  - Else: i--, go DBL.
- DONE (1 cycle): result=Q, done=1; busy drops on exit; go IDLE. A start on the cycle after DONE is accepted.
- Latency: 1 + (K_WIDTH − msb(k)) SCAN cycles + ALU_LAT × (#DBL + #ADD) + 1.
- #DBL = msb(k); #ADD = popcount(k) − 1.
- k=0: no ALU ops, result = infinity.
- k=1: no ALU ops, result = P.

Decomposition:
- Package ecc_pkg holds:
  - FE_W=4, POINT_W=12.
  - ALU_OP_ADD=1'b0, ALU_OP_DBL=1'b1.
  - POINT_INF=12'h010.
  - state enum type, and field-slice helper functions.
- Single module, no sub-module; the point ALU stays external so it can be shared or swapped.

Test Plan:
1. Bench ALU stub: add R=(A+B) mod 4096, double R=(2A) mod 4096. K_WIDTH=8, ALU_LAT=1, P=12'h123, k=8'h05 → op trace DBL,DBL,ADD; result=12'h5AF; done pulse exactly 1 cycle; busy high 10 cycles.
2. k=8'h00, P=12'h123 → zero ALU ops; result=12'h010; done after 9 cycles. Same with k=8'h01 → result=12'h123, zero ALU ops.
3. k=8'hFF, P=12'h001, stub ALU → 7 DBL and 7 ADD interleaved D,A,…; result=12'h0FF. Repeat with ALU_LAT=3: operands stable 3 cycles per op; same result.
4. Assert rst mid-DBL (k=8'h80), asynchronously between edges → outputs zero immediately, no done. A new start with k=8'h03, P=12'h010 → result=12'h030.
5. start held high throughout a run and pulsed while busy → ignored. Back-to-back start on the cycle after done → accepted; second result correct.
6. Integrated with the real point add/double ALU, P a valid curve point, k=2 → result equals ALU double(P) captured directly; k=3 → add(double(P), P).
